cpu_step_ctrl: RTL

Run/pause/single-step controller that sits directly downstream of the 50,000,000-count CPU clock divider. It consumes the divider's slow square wave `slow_clk`, which is generated by a register in the `clk` domain, and detects its rising edges in the `clk` domain. It gates those edges into one-cycle `cpu_ce` clock-enable pulses for the single-cycle CPU, under control of two debounced board pushbuttons. It also keeps a count of executed CPU cycles for the display logic.

---
 rtl/cpu_step_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/cpu_step_ctrl.sv
// Run/pause/single-step controller. Turns slow_clk rising edges into one-cycle
// cpu_ce pulses under control of two debounced pushbuttons, and counts the
// pulses issued.
module cpu_step_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned CNT_W           = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             slow_clk,
   input  logic             btn_run,
   input  logic             btn_step,
   output logic             cpu_ce,
   output logic             mode_run,
   output logic             step_armed,
   output logic [CNT_W-1:0] cycle_count
);

   localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      StPause,
      StRun,
      StStep
   } state_e;

   // Bit 0 is the run button, bit 1 the step button.
   logic [1:0]      sync1;
   logic [1:0]      sync2;
   logic [1:0]      deb;
   logic [1:0]      deb_d;
   logic [1:0]      press;
   logic [DB_W-1:0] db_cnt [2];

   logic   slow_clk_d;
   logic   tick;
   logic   run_p;
   logic   step_p;
   state_e state;

   assign run_p  = press[0];
   assign step_p = press[1];
   assign tick   = slow_clk & ~slow_clk_d;

   // Synchronize, debounce and turn debounced rising levels into one-cycle presses.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
         deb   <= '0;
         deb_d <= '0;
         press <= '0;
         for (int i = 0; i < 2; i++) begin
            db_cnt[i] <= '0;
         end
      end else begin
         sync1 <= {btn_step, btn_run};
         sync2 <= sync1;
         deb_d <= deb;
         press <= deb & ~deb_d;
         for (int i = 0; i < 2; i++) begin
            // Count consecutive cycles the synchronized level disagrees with the accepted one.
            if (sync2[i] == deb[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               deb[i]    <= sync2[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + DB_W'(1);
            end
         end
      end
   end

   // Delay slow_clk one cycle for rising-edge detection.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         slow_clk_d <= 1'b0;
      end else begin
         slow_clk_d <= slow_clk;
      end
   end

   // Run/pause/step state machine with registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= StPause;
         cpu_ce     <= 1'b0;
         mode_run   <= 1'b0;
         step_armed <= 1'b0;
      end else begin
         cpu_ce <= 1'b0;
         unique case (state)
            StPause: begin
               // run_p takes priority over a simultaneous step_p.
               if (run_p) begin
                  state    <= StRun;
                  mode_run <= 1'b1;
               end else if (step_p) begin
                  state      <= StStep;
                  step_armed <= 1'b1;
               end
            end
            StRun: begin
               // A tick coinciding with the pause request still executes.
               if (tick) begin
                  cpu_ce <= 1'b1;
               end
               if (run_p) begin
                  state    <= StPause;
                  mode_run <= 1'b0;
               end
            end
            StStep: begin
               if (tick) begin
                  cpu_ce <= 1'b1;
               end
               if (run_p) begin
                  state      <= StRun;
                  mode_run   <= 1'b1;
                  step_armed <= 1'b0;
               end else if (tick) begin
                  state      <= StPause;
                  step_armed <= 1'b0;
               end
            end
            default: begin
               state      <= StPause;
               mode_run   <= 1'b0;
               step_armed <= 1'b0;
            end
         endcase
      end
   end

   // Count issued enables; wraps silently.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cycle_count <= '0;
      end else if (cpu_ce) begin
         cycle_count <= cycle_count + CNT_W'(1);
      end
   end

endmodule
